// File: rtl/uart_frame_checker.sv
// uart_frame_checker
// Registered frame-integrity checker between the UART receive shift logic
// and the RX data path. Each accepted frame is checked for start, stop and
// parity errors against the runtime configuration, then held with its
// error flags in a one-entry valid/ready output stage. Sticky error status,
// a sticky overrun flag and saturating per-error counters are kept for
// software.
//
// Build option: define UART_ERR_COUNTERS_EN to implement the three error
// counters. When it is not defined, no counter registers exist and the
// counter outputs are tied to zero.

module uart_frame_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_two_stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_start_bit,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity_bit,
    input  logic [1:0]        in_stop_bits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_err,
    output logic [2:0]        sticky_err,
    output logic              overrun,
    input  logic              clr_status,
    output logic [CNT_W-1:0]  cnt_parity,
    output logic [CNT_W-1:0]  cnt_start,
    output logic [CNT_W-1:0]  cnt_stop
);

    logic       accept;
    logic       drop;
    logic       parity_err;
    logic       start_err;
    logic       stop_err;
    logic [2:0] new_err;

    // The output slot can take a new frame when empty or being drained now.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign drop     = in_valid && !in_ready;

    assign start_err = in_start_bit;
    assign stop_err  = !in_stop_bits[0] || (cfg_two_stop && !in_stop_bits[1]);
    assign new_err   = {stop_err, start_err, parity_err};

    // Parity check: odd/even compare the XOR of data plus parity bit, mark needs a 1.
    always_comb begin
        parity_err = 1'b0;
        case (cfg_parity)
            2'b01:   parity_err = ~(^{in_data, in_parity_bit});
            2'b10:   parity_err = ^{in_data, in_parity_bit};
            2'b11:   parity_err = ~in_parity_bit;
            default: parity_err = 1'b0;
        endcase
    end

    // One-entry output stage: load on accept, drop valid when drained, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 3'b000;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_err   <= new_err;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error bits: a same-cycle clear happens before the new frame's errors land.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_err <= 3'b000;
        end else if (accept) begin
            sticky_err <= (clr_status ? 3'b000 : sticky_err) | new_err;
        end else if (clr_status) begin
            sticky_err <= 3'b000;
        end
    end

    // Overrun flag: a dropped frame wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_status) begin
            overrun <= 1'b0;
        end
    end

`ifdef UART_ERR_COUNTERS_EN
    // Clear first, then add one for a hit unless already at all-ones.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cur,
        input logic             clr,
        input logic             hit
    );
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cur;
        if (hit && (base != '1)) begin
            return base + CNT_W'(1);
        end
        return base;
    endfunction

    // Saturating per-error counters, bumped only by accepted frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_parity <= '0;
            cnt_start  <= '0;
            cnt_stop   <= '0;
        end else begin
            cnt_parity <= next_count(cnt_parity, clr_status, accept && new_err[0]);
            cnt_start  <= next_count(cnt_start,  clr_status, accept && new_err[1]);
            cnt_stop   <= next_count(cnt_stop,   clr_status, accept && new_err[2]);
        end
    end
`else
    assign cnt_parity = '0;
    assign cnt_start  = '0;
    assign cnt_stop   = '0;
`endif

endmodule

// File: doc/uart_frame_checker.md
Name: uart_frame_checker

Overview:
Registered frame-integrity checker between the UART receive shift logic and the RX data path. It accepts one received frame per valid strobe and evaluates start, stop and parity against the runtime configuration, including 1 or 2 stop bits and none/odd/even/mark parity. Each accepted frame is presented with its error flags on a one-entry valid/ready output stage. The block also keeps sticky error status, an overrun indication and saturating per-error counters for software.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
CNT_W, 8, width of each error counter.

Ports:
clk  input  1  clock
reset  input  1  reset; synchronous, active-high
cfg_parity  input  2  00 none, 01 odd, 10 even, 11 mark (parity bit must be 1)
cfg_two_stop  input  1  1 = two stop bits are checked
in_valid  input  1  frame fields valid this cycle
in_ready  output  1  frame can be accepted this cycle
in_start_bit  input  1  sampled start bit; expected 0
in_data  input  DATA_W  received data bits
in_parity_bit  input  1  sampled parity bit; ignored when cfg_parity = 00
in_stop_bits  input  2  [0] first stop bit, [1] second stop bit; both expected 1
out_valid  output  1  output frame held
out_ready  input  1  consumer accepts the output frame
out_data  output  DATA_W  registered data
out_err  output  3  {stop_err, start_err, parity_err} for out_data
sticky_err  output  3  OR of all out_err values since the last clear
overrun  output  1  sticky flag: a frame was dropped
clr_status  input  1  clears sticky_err, overrun and all counters
cnt_parity  output  CNT_W  parity error count
cnt_start  output  CNT_W  start error count
cnt_stop  output  CNT_W  stop error count

Behaviour:
- Reset values: out_valid=0, out_data=0, out_err=0, sticky_err=0, overrun=0, all counters=0.
- in_ready = !out_valid || out_ready (combinational).
- Accept condition: in_valid && in_ready.
  - On accept: out_data, out_err and out_valid=1 load on the next edge. Latency is 1 cycle.
  - Back-to-back frames run at full rate while out_ready is held high.
- Hold condition: out_valid && !out_ready with no accept. Output registers stay stable.
- Drain condition: out_ready && out_valid with no accept. out_valid clears to 0.
- Overrun: in_valid && !in_ready drops the frame and sets overrun=1. Nothing else changes; no counter or sticky update.
- Error equations, evaluated on the input fields at accept:
  - start_err = in_start_bit.
  - stop_err = !in_stop_bits[0] || (cfg_two_stop && !in_stop_bits[1]).
  - parity_err when cfg_parity=01 (odd): ^{in_data, in_parity_bit} == 0.
  - parity_err when cfg_parity=10 (even): ^{in_data, in_parity_bit} == 1.
  - parity_err when cfg_parity=11 (mark): !in_parity_bit.
  - parity_err when cfg_parity=00 (none): 0.
- Sticky and counter update: on accept, sticky_err |= new err, and each counter increments by 1 when its error bit is set.
- Counter saturation: counters stop at all-ones (2^CNT_W-1) and do not wrap.
- clr_status in the same cycle as an accept: the clear applies first, then the new frame's errors are applied. Result is sticky_err = new err and counters = 0 or 1.
- clr_status in the same cycle as a drop: overrun ends at 1.
- Configuration inputs are sampled only at accept. Changes while a frame is held have no effect on that frame's out_err.
- Reset mid-operation: a held frame is discarded, and all state returns to the reset values on the next edge.

Optional Feature:
UART_ERR_COUNTERS_EN
- Defined: cnt_parity, cnt_start and cnt_stop are implemented as specified above.
- Not defined: no counter registers exist, and the three counter outputs are tied to constant 0. sticky_err, overrun and the handshake behaviour are unchanged.

Test Plan:
1. cfg_parity=01, in_data=8'hA5 (four ones), in_parity_bit=1, start=0, stops=2'b11, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_err=000. Repeat with parity_bit=0 -> out_err=001, cnt_parity=1, sticky_err=001.
2. cfg_two_stop=1, in_stop_bits=2'b01, in_start_bit=1, cfg_parity=00 -> out_err=110; cnt_start=1, cnt_stop=1. Repeat with cfg_two_stop=0 -> out_err=010.
3. out_ready=0, frame 8'h11 accepted, then a second frame 8'h22 presented -> in_ready=0, overrun=1, out_data stays 11. Raise out_ready -> 11 drains, out_valid=0, and 22 never appears.
4. CNT_W=2, five parity-error frames -> cnt_parity sequence 1,2,3,3,3.
5. clr_status asserted in the same cycle as accepting a start-error frame, with prior sticky_err=011 -> sticky_err=010, cnt_start=1, other counters 0.
6. Reset asserted while out_valid=1 and counters nonzero -> next edge out_valid=0, all outputs 0. Build with UART_ERR_COUNTERS_EN undefined -> counters read 0 in scenarios 1-5.
